hub_nonce_scheduler: RTL and testbench
======================================

Name: hub_nonce_scheduler

Overview:
- Collects golden nonces from SLAVES mining cores and grants them to one shared UART transmitter using round-robin arbitration.
- Each nonce is sent as a 5-byte frame: slave ID byte, then the nonce MSB first.
- Each slave has a holding register, so a nonce that arrives while the link is busy is kept until it can be sent.
- Sits between the per-slave miners and the serial_transmit byte engine of the cluster hub.

Parameters:
- SLAVES, 2, number of nonce sources (1..255)
- CNT_W, 16, width of the saturating dropped-nonce counter

Ports:
- hash_clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- new_nonces  in  SLAVES  one-cycle pulse per slave: nonce valid
- slave_nonces  in  SLAVES*32  slave i nonce at bits [32i+31:32i]
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle start pulse to transmitter
- tx_busy  in  1  transmitter busy; rises no later than 1 cycle after tx_start
- frame_active  out  1  a frame is in progress
- overflow  out  SLAVES  sticky flag per slave: a nonce was dropped
- drop_count  out  CNT_W  saturating total of dropped nonces
- clear_overflow  in  1  synchronous clear of overflow and drop_count

Behaviour:
- Reset (async assert, sync release): tx_start=0, tx_data=0, frame_active=0, overflow=0, drop_count=0, all pending flags 0, rr pointer=0, state IDLE.
- Capture:
  - new_nonces[i] with pending[i]=0: latch the slave i nonce into hold[i] and set pending[i] on the next edge.
  - new_nonces[i] with pending[i]=1: keep the old nonce, set overflow[i], increment drop_count (saturates at all-ones).
  - Several slaves in one cycle: each is captured independently.
- Arbitration (IDLE only): grant the first pending slave at or after rr pointer, wrapping modulo SLAVES.
  - On grant: copy hold[g] into the frame shift register, set sel_id=g, clear pending[g], set rr=(g+1) mod SLAVES, go to SEND.
  - Grant-cycle clear together with new_nonces[g] in the same cycle: the new nonce is captured and pending[g] stays 1. This is not counted as a drop.
- FSM states: IDLE, SEND, GUARD, WAIT.
  - SEND: when tx_busy=0, register tx_start=1 and tx_data=current byte, then go to GUARD. Byte order: sel_id, nonce[31:24], [23:16], [15:8], [7:0].
  - GUARD: one cycle; tx_start returns to 0. Go to WAIT.
  - WAIT: when tx_busy=0, if 5 bytes have been sent go to IDLE, else advance the byte index and go to SEND.
- frame_active=1 in every state except IDLE.
- tx_data holds its last value between pulses.
- Latency: new_nonces[i] at cycle N with idle link gives pending at N+1, grant at N+1, SEND at N+2, first tx_start high at N+3.
- Back-to-back frames: IDLE re-arbitrates in the cycle it is entered; there is no extra gap beyond WAIT→IDLE→SEND.
- clear_overflow and a drop in the same cycle: the clear wins, then the drop applies (overflow[i]=1, drop_count=1).
- tx_busy stuck high: the FSM waits indefinitely and captures continue; there is no timeout.
- Reset mid-frame: the frame is aborted, no further bytes are sent, and all pending nonces are lost.

Decomposition:
- Package hub_pkg:
  - FRAME_BYTES=5
  - state enum {IDLE, SEND, GUARD, WAIT}
  - function rr_pick(pending, ptr), returning the granted index and a valid bit
- Sub-module nonce_holding_bank: per-slave hold registers, pending flags, overflow and drop counting.
- The FSM and arbiter stay in the top module.

Test Plan:
- Single nonce, SLAVES=2: slave 1 pulses 0xDEADBEEF with tx_busy modelled as 10 cycles per byte → bytes 0x01,0xDE,0xAD,0xBE,0xEF in order; first tx_start at pulse+3; frame_active drops after the last byte.
- Simultaneous: both slaves pulse in the same cycle with rr=0 → frame for slave 0 then slave 1; rr ends at 0; no overflow.
- Overflow: slave 0 pulses 0x11111111, then 0x22222222 while the first is still pending → 0x11111111 sent, overflow[0]=1, drop_count=1; clear_overflow → both return to 0.
- Grant collision: slave 0 pulses in the grant cycle → the second frame carries the new nonce and drop_count stays 0.
- Fairness, SLAVES=4: all slaves re-pulse continuously → grant order 0,1,2,3,0,… with no slave starved.
- Reset mid-frame: assert rst_n low after the 2nd byte → tx_start low immediately, all outputs at reset values, and no bytes after release until a new pulse.

Source files
------------

// File: rtl/hub_pkg.sv
// Shared types and helpers for the nonce hub: frame length, FSM encoding and
// the round-robin picker used by the scheduler.
package hub_pkg;

  localparam int unsigned FRAME_BYTES = 5;
  localparam int unsigned MAX_SLAVES  = 256;

  typedef enum logic [1:0] {IDLE, SEND, GUARD, WAIT} state_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] idx;
  } pick_t;

  // First set bit of pending at or after ptr, wrapping modulo nslaves.
  // Scanning offsets downwards lets the smallest offset overwrite the result.
  function automatic pick_t rr_pick(input logic [MAX_SLAVES-1:0] pending,
                                    input logic [7:0]            ptr,
                                    input int unsigned           nslaves);
    pick_t       r;
    int unsigned j;
    r = '0;
    for (int k = MAX_SLAVES - 1; k >= 0; k--) begin
      if (k < int'(nslaves)) begin
        j = 32'(ptr) + 32'(k);
        if (j >= nslaves) j = j - nslaves;
        if (pending[j[7:0]]) begin
          r.valid = 1'b1;
          r.idx   = j[7:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nonce_holding_bank.sv
// Per-slave nonce holding registers with pending flags, sticky overflow flags
// and a saturating count of nonces dropped because a slot was still occupied.
module nonce_holding_bank
  import hub_pkg::*;
#(
  parameter int unsigned SLAVES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SLAVES-1:0]    new_nonces,
  input  logic [SLAVES*32-1:0] slave_nonces,
  input  logic                 grant_valid,
  input  logic [7:0]           grant_idx,
  input  logic                 clear_overflow,
  output logic [SLAVES-1:0]    pending,
  output logic [SLAVES*32-1:0] hold,
  output logic [SLAVES-1:0]    overflow,
  output logic [CNT_W-1:0]     drop_count
);

  logic [SLAVES-1:0]    pending_q, pending_d;
  logic [SLAVES-1:0]    overflow_q, overflow_d;
  logic [SLAVES*32-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]     drop_count_q, drop_count_d;

  // The grant clear is applied first, so a nonce arriving in its own grant
  // cycle sees a free slot and is captured rather than dropped.
  always_comb begin
    pending_d    = pending_q;
    hold_d       = hold_q;
    overflow_d   = clear_overflow ? '0 : overflow_q;
    drop_count_d = clear_overflow ? '0 : drop_count_q;
    for (int i = 0; i < int'(SLAVES); i++) begin
      if (grant_valid && grant_idx == 8'(i)) pending_d[i] = 1'b0;
      if (new_nonces[i]) begin
        if (pending_d[i]) begin
          overflow_d[i] = 1'b1;
          if (drop_count_d != '1) drop_count_d = drop_count_d + CNT_W'(1);
        end else begin
          hold_d[32*i +: 32] = slave_nonces[32*i +: 32];
          pending_d[i]       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      overflow_q   <= '0;
      hold_q       <= '0;
      drop_count_q <= '0;
    end else begin
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      hold_q       <= hold_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign pending    = pending_q;
  assign hold       = hold_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: rtl/hub_nonce_scheduler.sv
// Round-robin scheduler that frames held nonces as {slave id, nonce MSB first}
// and feeds them byte by byte to the shared UART transmitter.
module hub_nonce_scheduler
  import hub_pkg::*;
#(
  parameter int unsigned SLAVES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 hash_clk,
  input  logic                 rst_n,
  input  logic [SLAVES-1:0]    new_nonces,
  input  logic [SLAVES*32-1:0] slave_nonces,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 frame_active,
  output logic [SLAVES-1:0]    overflow,
  output logic [CNT_W-1:0]     drop_count,
  input  logic                 clear_overflow
);

  logic [SLAVES-1:0]     pending;
  logic [SLAVES*32-1:0]  hold;
  logic [MAX_SLAVES-1:0] pending_ext;
  pick_t                 pick;
  logic                  grant_valid;

  state_e      state_q, state_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [31:0] shift_q, shift_d;
  logic [7:0]  sel_id_q, sel_id_d;
  logic [7:0]  rr_q, rr_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  cur_byte;

  nonce_holding_bank #(.SLAVES(SLAVES), .CNT_W(CNT_W)) u_bank (
    .clk            (hash_clk),
    .rst_n          (rst_n),
    .new_nonces     (new_nonces),
    .slave_nonces   (slave_nonces),
    .grant_valid    (grant_valid),
    .grant_idx      (pick.idx),
    .clear_overflow (clear_overflow),
    .pending        (pending),
    .hold           (hold),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  assign pending_ext = {{(MAX_SLAVES-SLAVES){1'b0}}, pending};
  assign pick        = rr_pick(pending_ext, rr_q, SLAVES);

  always_comb begin
    case (byte_idx_q)
      3'd0:    cur_byte = sel_id_q;
      3'd1:    cur_byte = shift_q[31:24];
      3'd2:    cur_byte = shift_q[23:16];
      3'd3:    cur_byte = shift_q[15:8];
      default: cur_byte = shift_q[7:0];
    endcase
  end

  // Handshake: a byte is offered only while tx_busy is low; tx_start is a
  // one-cycle pulse, and GUARD gives tx_busy one cycle to rise before WAIT.
  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    shift_d     = shift_q;
    sel_id_d    = sel_id_q;
    rr_d        = rr_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    grant_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick.valid) begin
          grant_valid = 1'b1;
          shift_d     = hold[32*int'(pick.idx) +: 32];
          sel_id_d    = pick.idx;
          rr_d        = (pick.idx == 8'(SLAVES - 1)) ? 8'd0 : pick.idx + 8'd1;
          byte_idx_d  = 3'd0;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = cur_byte;
          state_d    = GUARD;
        end
      end
      GUARD: state_d = WAIT;
      WAIT: begin
        if (!tx_busy) begin
          if (byte_idx_q == 3'(FRAME_BYTES - 1)) begin
            state_d = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hash_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      shift_q    <= '0;
      sel_id_q   <= '0;
      rr_q       <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      sel_id_q   <= sel_id_d;
      rr_q       <= rr_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign frame_active = (state_q != IDLE);

endmodule

// File: tb/tb_hub_nonce_scheduler.sv
// Scoreboard bench: stimulus pushes expected frame bytes, per-DUT monitors pop
// and compare on every tx_start. DUT A has 2 slaves, DUT B has 4 for fairness.
module tb_hub_nonce_scheduler;

  localparam int BYTE_CYC = 10;
  localparam int TIMEOUT  = 3000;

  logic hash_clk = 1'b0;
  logic rst_n    = 1'b0;
  always #5 hash_clk = ~hash_clk;

  int cyc = 0;
  always @(posedge hash_clk) cyc <= cyc + 1;

  logic [1:0]   new_a;
  logic [63:0]  nonces_a;
  logic         clr_a;
  logic [7:0]   tx_data_a;
  logic         tx_start_a, tx_busy_a, frame_active_a;
  logic [1:0]   ovf_a;
  logic [15:0]  drop_a;

  logic [3:0]   new_b;
  logic [127:0] nonces_b;
  logic         clr_b;
  logic [7:0]   tx_data_b;
  logic         tx_start_b, tx_busy_b, frame_active_b;
  logic [3:0]   ovf_b;
  logic [15:0]  drop_b;

  hub_nonce_scheduler #(.SLAVES(2), .CNT_W(16)) u_a (
    .hash_clk(hash_clk), .rst_n(rst_n), .new_nonces(new_a), .slave_nonces(nonces_a),
    .tx_data(tx_data_a), .tx_start(tx_start_a), .tx_busy(tx_busy_a),
    .frame_active(frame_active_a), .overflow(ovf_a), .drop_count(drop_a),
    .clear_overflow(clr_a)
  );

  hub_nonce_scheduler #(.SLAVES(4), .CNT_W(16)) u_b (
    .hash_clk(hash_clk), .rst_n(rst_n), .new_nonces(new_b), .slave_nonces(nonces_b),
    .tx_data(tx_data_b), .tx_start(tx_start_b), .tx_busy(tx_busy_b),
    .frame_active(frame_active_b), .overflow(ovf_b), .drop_count(drop_b),
    .clear_overflow(clr_b)
  );

  // Transmitter models: busy for BYTE_CYC cycles after each start pulse.
  int busy_cnt_a = 0;
  int busy_cnt_b = 0;
  always @(negedge hash_clk or negedge rst_n) begin
    if (!rst_n) busy_cnt_a = 0;
    else if (tx_start_a) busy_cnt_a = BYTE_CYC;
    else if (busy_cnt_a > 0) busy_cnt_a = busy_cnt_a - 1;
  end
  always @(negedge hash_clk or negedge rst_n) begin
    if (!rst_n) busy_cnt_b = 0;
    else if (tx_start_b) busy_cnt_b = BYTE_CYC;
    else if (busy_cnt_b > 0) busy_cnt_b = busy_cnt_b - 1;
  end
  assign tx_busy_a = (busy_cnt_a != 0);
  assign tx_busy_b = (busy_cnt_b != 0);

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];
  logic [7:0] exp_byte_a, exp_byte_b;
  int a_bytes = 0;
  int b_bytes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge hash_clk) begin
    if (rst_n && tx_start_a) begin
      a_bytes++;
      check("a_frame_active_in_frame", frame_active_a, 1);
      if (exp_a_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_byte actual=%02h required=no byte", tx_data_a);
      end else begin
        exp_byte_a = exp_a_q.pop_front();
        check("a_tx_byte", tx_data_a, exp_byte_a);
      end
    end
  end

  always @(negedge hash_clk) begin
    if (rst_n && tx_start_b) begin
      b_bytes++;
      if (exp_b_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_byte actual=%02h required=no byte", tx_data_b);
      end else begin
        exp_byte_b = exp_b_q.pop_front();
        check("b_tx_byte", tx_data_b, exp_byte_b);
      end
    end
  end

  task automatic push_frame_a(input logic [7:0] id, input logic [31:0] n);
    exp_a_q.push_back(id);
    exp_a_q.push_back(n[31:24]);
    exp_a_q.push_back(n[23:16]);
    exp_a_q.push_back(n[15:8]);
    exp_a_q.push_back(n[7:0]);
  endtask

  task automatic push_frame_b(input logic [7:0] id, input logic [31:0] n);
    exp_b_q.push_back(id);
    exp_b_q.push_back(n[31:24]);
    exp_b_q.push_back(n[23:16]);
    exp_b_q.push_back(n[15:8]);
    exp_b_q.push_back(n[7:0]);
  endtask

  task automatic drive_a(input logic [1:0] mask, input logic [31:0] n0, input logic [31:0] n1);
    @(negedge hash_clk);
    new_a    = mask;
    nonces_a = {n1, n0};
  endtask

  task automatic idle_a();
    @(negedge hash_clk);
    new_a = 2'b00;
    clr_a = 1'b0;
  endtask

  task automatic wait_a_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge hash_clk);
      #1;
      n++;
    end while (!(exp_a_q.size() == 0 && !frame_active_a) && n < TIMEOUT);
    check(name, (n < TIMEOUT), 1);
  endtask

  task automatic wait_a_bytes(input string name, input int target);
    int n;
    n = 0;
    do begin
      @(negedge hash_clk);
      #1;
      n++;
    end while (a_bytes < target && n < TIMEOUT);
    check(name, (n < TIMEOUT), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulse_cyc, n, base;
    new_a = '0; nonces_a = '0; clr_a = 1'b0;
    new_b = '0; nonces_b = '0; clr_b = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(negedge hash_clk);
    #1;
    check("rst_tx_start", tx_start_a, 0);
    check("rst_tx_data", tx_data_a, 0);
    check("rst_frame_active", frame_active_a, 0);
    check("rst_overflow", ovf_a, 0);
    check("rst_drop_count", drop_a, 0);
    check("rst_b_frame_active", frame_active_b, 0);
    @(negedge hash_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge hash_clk);

    // Single nonce from slave 1, with first-start latency.
    push_frame_a(8'h01, 32'hDEADBEEF);
    drive_a(2'b10, 32'h0, 32'hDEADBEEF);
    pulse_cyc = cyc;
    idle_a();
    n = 0;
    while (!tx_start_a && n < 20) begin
      @(negedge hash_clk);
      n++;
    end
    check("a_first_start_latency", cyc - pulse_cyc, 3);
    wait_a_idle("a_single_done");
    check("a_single_frame_active_low", frame_active_a, 0);
    check("a_tx_data_holds", tx_data_a, 8'hEF);

    // Both slaves at once: slave 0 first, then slave 1, pointer back to 0.
    push_frame_a(8'h00, 32'hA0A1A2A3);
    push_frame_a(8'h01, 32'hB0B1B2B3);
    drive_a(2'b11, 32'hA0A1A2A3, 32'hB0B1B2B3);
    idle_a();
    wait_a_idle("a_simul_done");
    check("a_simul_overflow", ovf_a, 0);
    check("a_simul_drop", drop_a, 0);
    check("a_simul_rr", u_a.rr_q, 0);

    // Overflow: second slave-0 nonce arrives while the first is still held.
    push_frame_a(8'h01, 32'h33333333);
    push_frame_a(8'h00, 32'h11111111);
    drive_a(2'b10, 32'h0, 32'h33333333);
    idle_a();
    repeat (3) @(negedge hash_clk);
    drive_a(2'b01, 32'h11111111, 32'h0);
    drive_a(2'b01, 32'h22222222, 32'h0);
    idle_a();
    wait_a_idle("a_ovf_done");
    check("a_ovf_flag", ovf_a, 2'b01);
    check("a_ovf_drop", drop_a, 1);

    // Clear and drop in the same cycle: clear first, then the drop lands.
    push_frame_a(8'h01, 32'h44444444);
    push_frame_a(8'h00, 32'h55555555);
    drive_a(2'b10, 32'h0, 32'h44444444);
    idle_a();
    repeat (3) @(negedge hash_clk);
    drive_a(2'b01, 32'h55555555, 32'h0);
    drive_a(2'b01, 32'h66666666, 32'h0);
    clr_a = 1'b1;
    idle_a();
    wait_a_idle("a_clrdrop_done");
    check("a_clrdrop_flag", ovf_a, 2'b01);
    check("a_clrdrop_drop", drop_a, 1);

    @(negedge hash_clk);
    clr_a = 1'b1;
    @(negedge hash_clk);
    clr_a = 1'b0;
    #1;
    check("a_clear_flag", ovf_a, 0);
    check("a_clear_drop", drop_a, 0);

    // Grant collision: new slave-0 nonce in its own grant cycle is kept.
    push_frame_a(8'h00, 32'h77777777);
    push_frame_a(8'h00, 32'h88888888);
    drive_a(2'b01, 32'h77777777, 32'h0);
    drive_a(2'b01, 32'h88888888, 32'h0);
    idle_a();
    wait_a_idle("a_collision_done");
    check("a_collision_drop", drop_a, 0);
    check("a_collision_flag", ovf_a, 0);

    // Reset after the 2nd byte of a frame, with slave 0 also holding a nonce.
    base = a_bytes;
    exp_a_q.push_back(8'h01);
    exp_a_q.push_back(8'h12);
    drive_a(2'b10, 32'h0, 32'h12345678);
    idle_a();
    repeat (2) @(negedge hash_clk);
    drive_a(2'b01, 32'h9ABCDEF0, 32'h0);
    idle_a();
    wait_a_bytes("a_mid_two_bytes", base + 2);
    rst_n = 1'b0;
    #1;
    check("a_midrst_tx_start", tx_start_a, 0);
    check("a_midrst_tx_data", tx_data_a, 0);
    check("a_midrst_frame_active", frame_active_a, 0);
    check("a_midrst_overflow", ovf_a, 0);
    check("a_midrst_drop", drop_a, 0);
    repeat (2) @(negedge hash_clk);
    rst_n = 1'b1;
    repeat (80) @(negedge hash_clk);
    #1;
    check("a_post_rst_idle", frame_active_a, 0);
    check("a_post_rst_bytes", a_bytes, base + 2);
    push_frame_a(8'h00, 32'hCAFEF00D);
    drive_a(2'b01, 32'hCAFEF00D, 32'h0);
    idle_a();
    wait_a_idle("a_post_rst_frame");

    // Fairness on the 4-slave instance: all slaves re-pulse every cycle.
    for (int k = 0; k < 12; k++) push_frame_b(8'(k % 4), 32'hF0E0D0C0 + 32'(k % 4));
    @(negedge hash_clk);
    nonces_b = {32'hF0E0D0C3, 32'hF0E0D0C2, 32'hF0E0D0C1, 32'hF0E0D0C0};
    new_b    = 4'hF;
    n = 0;
    do begin
      @(negedge hash_clk);
      #1;
      n++;
    end while (b_bytes < 40 && n < TIMEOUT);
    new_b = 4'h0;
    check("b_forty_bytes", (n < TIMEOUT), 1);
    n = 0;
    do begin
      @(negedge hash_clk);
      #1;
      n++;
    end while (!(exp_b_q.size() == 0 && !frame_active_b) && n < TIMEOUT);
    check("b_drain", (n < TIMEOUT), 1);
    check("b_total_bytes", b_bytes, 60);

    repeat (20) @(negedge hash_clk);
    check("a_queue_empty", exp_a_q.size(), 0);
    check("b_queue_empty", exp_b_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
